// File: rtl/cfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfi_pkg
// Description : Shared definitions for the CFI log writer and checker:
//               log table bounds, slot stride, writer state encoding and
//               the circular log-pointer advance.
// Revision    : 1.0 - initial release
// ============================================================================
package cfi_pkg;

    localparam int          C_PTR_W             = 32;
    localparam logic [31:0] C_LOGTABLE_ADDRINIT = 32'h1FEF_F400;
    localparam logic [31:0] C_LOGTABLE_ADDREND  = 32'h1FEF_F7FC;
    localparam logic [31:0] C_LOG_STRIDE        = 32'd4;

    // Writer state encoding
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_UPDATE = 2'd2
    } wr_state_t;

    // Advance a log pointer by one slot, wrapping from the last slot to the first
    function automatic logic [C_PTR_W-1:0] next_log_ptr(
        input logic [C_PTR_W-1:0] ptr,
        input logic [C_PTR_W-1:0] first_slot,
        input logic [C_PTR_W-1:0] last_slot
    );
        next_log_ptr = (ptr == last_slot) ? first_slot : ptr + C_LOG_STRIDE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfi_branch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cfi_branch_fifo
// Description : Small synchronous FIFO holding captured branch targets.
//               Head data is presented combinationally. A push on a full
//               FIFO is accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cfi_branch_fifo #(
    parameter int FIFO_DEPTH   = 4,
    parameter int N_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [N_DATA_WIDTH-1:0] i_data,
    input  logic                    i_pop,
    output logic [N_DATA_WIDTH-1:0] o_data,
    output logic                    o_full,
    output logic                    o_empty
);
    import cfi_pkg::*;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [N_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic                    w_do_pop;
    logic                    w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since the pointers qualify them
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cfi_log_writer.sv
`default_nettype none
// ============================================================================
// Module      : cfi_log_writer
// Description : Captures branch targets into a FIFO and writes them, one word
//               per slot, into the circular RAM log table. Publishes the
//               updated write pointer with a one-cycle trigger after each
//               completed write and stalls rather than overrun unread slots.
// Revision    : 1.0 - initial release
// ============================================================================
module cfi_log_writer
    import cfi_pkg::*;
#(
    parameter int                      N_ADDR_WIDTH      = 32,
    parameter int                      N_DATA_WIDTH      = 32,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = N_ADDR_WIDTH'(C_LOGTABLE_ADDRINIT),
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = N_ADDR_WIDTH'(C_LOGTABLE_ADDREND),
    parameter int                      FIFO_DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_branch_vld,
    input  logic [N_DATA_WIDTH-1:0] i_branch_addr,
    input  logic                    i_halt,
    input  logic [N_ADDR_WIDTH-1:0] i_rdAddrptr,
    output logic                    o_wrReq,
    output logic [N_ADDR_WIDTH-1:0] o_wrAddr,
    output logic [N_DATA_WIDTH-1:0] o_wrData,
    input  logic                    i_wrDone,
    output logic [N_ADDR_WIDTH-1:0] o_logAddrptr,
    output logic                    o_trigger,
    output logic                    o_logFull,
    output logic [15:0]             o_dropCnt
);

    wr_state_t               r_state;
    wr_state_t               w_state_nxt;
    logic [N_ADDR_WIDTH-1:0] r_wr_addr;
    logic [N_DATA_WIDTH-1:0] r_wr_data;
    logic [N_ADDR_WIDTH-1:0] r_log_ptr;
    logic [15:0]             r_drop_cnt;

    logic [N_DATA_WIDTH-1:0] w_fifo_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [N_ADDR_WIDTH-1:0] w_next_ptr;
    logic                    w_table_full;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_wr_req;
    logic                    w_trigger;
    logic                    w_log_full;

    cfi_branch_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .N_DATA_WIDTH (N_DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_branch_vld),
        .i_data  (i_branch_addr),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // One slot is always left empty, so the table is full when the next
    // write slot would land on the checker's read pointer.
    assign w_next_ptr   = N_ADDR_WIDTH'(next_log_ptr(C_PTR_W'(r_log_ptr),
                                                     C_PTR_W'(LOGTABLE_ADDRINIT),
                                                     C_PTR_W'(LOGTABLE_ADDREND)));
    assign w_table_full = (w_next_ptr == i_rdAddrptr);
    assign w_pop        = (r_state == S_IDLE) && !w_fifo_empty && !i_halt && !w_table_full;
    // A push into a full FIFO survives only if the same cycle frees a slot
    assign w_drop       = i_branch_vld && w_fifo_full && !w_pop;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_wr_req    = 1'b0;
        w_trigger   = 1'b0;
        w_log_full  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_log_full = !w_fifo_empty && w_table_full;
                if (w_pop) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wr_req = 1'b1;
                if (i_wrDone) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_trigger   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write address/data latch on pop, pointer advance on completion, drop count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_addr  <= LOGTABLE_ADDRINIT;
            r_wr_data  <= '0;
            r_log_ptr  <= LOGTABLE_ADDRINIT;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_wr_addr <= r_log_ptr;
                r_wr_data <= w_fifo_head;
            end
            if ((r_state == S_WRITE) && i_wrDone) begin
                r_log_ptr <= w_next_ptr;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_wrReq      = w_wr_req;
    assign o_wrAddr     = r_wr_addr;
    assign o_wrData     = r_wr_data;
    assign o_logAddrptr = r_log_ptr;
    assign o_trigger    = w_trigger;
    assign o_logFull    = w_log_full;
    assign o_dropCnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cfi_log_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfi_log_writer
// Description : Directed self-checking bench for cfi_log_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfi_log_writer;

    localparam logic [31:0] C_INIT = 32'h1FEF_F400;
    localparam logic [31:0] C_END  = 32'h1FEF_F7FC;

    logic        clk;
    logic        rst;
    logic        r_branch_vld;
    logic [31:0] r_branch_addr;
    logic        r_halt;
    logic [31:0] r_rd_ptr;
    logic        r_wr_done;
    logic        w_wr_req;
    logic [31:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [31:0] w_log_ptr;
    logic        w_trigger;
    logic        w_log_full;
    logic [15:0] w_drop_cnt;

    int          r_n_tests = 0;
    int          r_n_fail  = 0;
    logic [31:0] r_exp_ptr;

    cfi_log_writer u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_branch_vld  (r_branch_vld),
        .i_branch_addr (r_branch_addr),
        .i_halt        (r_halt),
        .i_rdAddrptr   (r_rd_ptr),
        .o_wrReq       (w_wr_req),
        .o_wrAddr      (w_wr_addr),
        .o_wrData      (w_wr_data),
        .i_wrDone      (r_wr_done),
        .o_logAddrptr  (w_log_ptr),
        .o_trigger     (w_trigger),
        .o_logFull     (w_log_full),
        .o_dropCnt     (w_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_tests++;
        if (got !== exp) begin
            r_n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p);
        model_next = (p == C_END) ? C_INIT : p + 32'd4;
    endfunction

    task automatic push(input logic [31:0] a);
        r_branch_vld  = 1'b1;
        r_branch_addr = a;
        tick();
        r_branch_vld  = 1'b0;
    endtask

    // Wait for a request, check it, complete it after 'dly' cycles, check the update
    task automatic serve(input logic [31:0] exp_data, input int dly);
        int n;
        n = 0;
        while (!w_wr_req && n < 50) begin
            tick();
            n++;
        end
        if (!w_wr_req) begin
            check("req_timeout", 32'(w_wr_req), 32'd1);
        end else begin
            check("wr_addr", w_wr_addr, r_exp_ptr);
            check("wr_data", w_wr_data, exp_data);
            repeat (dly) tick();
            check("req_held", 32'(w_wr_req), 32'd1);
            r_wr_done = 1'b1;
            tick();
            r_wr_done = 1'b0;
            r_exp_ptr = model_next(r_exp_ptr);
            check("req_drop", 32'(w_wr_req), 32'd0);
            check("trig_hi", 32'(w_trigger), 32'd1);
            check("log_ptr", w_log_ptr, r_exp_ptr);
            tick();
            check("trig_lo", 32'(w_trigger), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ev [6];
        rst           = 1'b0;
        r_branch_vld  = 1'b0;
        r_branch_addr = '0;
        r_halt        = 1'b0;
        r_rd_ptr      = 32'h0;
        r_wr_done     = 1'b0;
        r_exp_ptr     = C_INIT;
        repeat (3) tick();

        // Reset state
        check("rst_req",  32'(w_wr_req),   32'd0);
        check("rst_addr", w_wr_addr,       C_INIT);
        check("rst_data", w_wr_data,       32'd0);
        check("rst_ptr",  w_log_ptr,       C_INIT);
        check("rst_trig", 32'(w_trigger),  32'd0);
        check("rst_full", 32'(w_log_full), 32'd0);
        check("rst_drop", 32'(w_drop_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // Single event, request one cycle after push, done 2 cycles later
        push(32'h0040_1000);
        check("single_nopop", 32'(w_wr_req), 32'd0);
        tick();
        check("single_req", 32'(w_wr_req), 32'd1);
        serve(32'h0040_1000, 2);
        check("single_ptr", w_log_ptr, 32'h1FEF_F404);

        // Table full: next slot 408 equals read pointer
        r_rd_ptr = 32'h1FEF_F408;
        push(32'hAAAA_0001);
        tick();
        tick();
        check("full_noreq", 32'(w_wr_req),   32'd0);
        check("full_flag",  32'(w_log_full), 32'd1);
        r_rd_ptr = 32'h1FEF_F40C;
        #1;
        check("full_clear", 32'(w_log_full), 32'd0);
        tick();
        check("full_release", 32'(w_wr_req), 32'd1);
        serve(32'hAAAA_0001, 0);
        r_rd_ptr = 32'h0;

        // Six back-to-back events with completion held off
        for (int i = 0; i < 6; i++) ev[i] = 32'hB000_0000 + 32'(i);
        for (int i = 0; i < 6; i++) begin
            r_branch_vld  = 1'b1;
            r_branch_addr = ev[i];
            tick();
        end
        r_branch_vld = 1'b0;
        check("drop_cnt", 32'(w_drop_cnt), 32'd1);
        for (int i = 0; i < 5; i++) serve(ev[i], 0);
        tick();
        check("drop_noextra", 32'(w_wr_req), 32'd0);

        // Halt during WRITE: current write finishes, next waits for halt release
        push(32'hC000_0001);
        push(32'hC000_0002);
        check("halt_req", 32'(w_wr_req), 32'd1);
        r_halt = 1'b1;
        serve(32'hC000_0001, 1);
        repeat (4) tick();
        check("halt_hold", 32'(w_wr_req), 32'd0);
        r_halt = 1'b0;
        tick();
        check("halt_resume", 32'(w_wr_req), 32'd1);
        serve(32'hC000_0002, 0);

        // Advance to the last slot, then write across the wrap
        while (r_exp_ptr != C_END) begin
            push(r_exp_ptr);
            serve(r_exp_ptr, 0);
        end
        check("pre_wrap_ptr", w_log_ptr, C_END);
        push(32'hD000_0001);
        serve(32'hD000_0001, 1);
        check("wrap_ptr", w_log_ptr, C_INIT);

        // Reset while a write is pending, with a second event still queued
        push(32'hE000_0001);
        push(32'hE000_0002);
        check("prerst_req", 32'(w_wr_req), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_req",  32'(w_wr_req),   32'd0);
        check("arst_addr", w_wr_addr,       C_INIT);
        check("arst_data", w_wr_data,       32'd0);
        check("arst_ptr",  w_log_ptr,       C_INIT);
        check("arst_drop", 32'(w_drop_cnt), 32'd0);
        check("arst_full", 32'(w_log_full), 32'd0);
        tick();
        rst = 1'b1;
        r_wr_done = 1'b1;
        tick();
        r_wr_done = 1'b0;
        check("late_done_trig", 32'(w_trigger), 32'd0);
        tick();
        check("late_done_trig2", 32'(w_trigger), 32'd0);
        check("late_done_ptr",   w_log_ptr,      C_INIT);
        repeat (3) tick();
        check("post_rst_noreq",  32'(w_wr_req),  32'd0);

        $display("[TB] %0d tests run, %0d failed", r_n_tests, r_n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
